// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, bit positions,
// func3 operation encodings and the read-only address predicate.
package csr_pkg;

  // Machine information / trap setup / trap handling
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH      = 12'h310;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  // Counter windows; the low five address bits select the counter
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_TIMEH         = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_HPMCOUNTER3H  = 12'hC83;

  localparam int CNT_IDX_CYCLE   = 0;
  localparam int CNT_IDX_TIME    = 1;
  localparam int CNT_IDX_INSTRET = 2;
  localparam int CNT_IDX_HPM0    = 3;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSI      = 3;
  localparam int MIP_MTI      = 7;
  localparam int MIP_MEI      = 11;

  localparam logic [31:0] MIE_WMASK = 32'hFFFF_0888;
  localparam logic [31:0] MISA_VAL  = 32'h4000_0100;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// One CNT_WIDTH-bit event counter with inhibit and 32-bit half-word writes.
// A write in the same cycle as an increment takes precedence.
module csr_counter
  import csr_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 inhibit,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] value
);

  logic [CNT_WIDTH-1:0] value_reg;
  logic [CNT_WIDTH-1:0] value_next;
  logic [CNT_WIDTH-1:0] hi_merged;
  logic                 hi_writable;

  generate
    if (CNT_WIDTH > 32) begin : g_wide
      assign hi_merged   = {wdata[CNT_WIDTH-33:0], value_reg[31:0]};
      assign hi_writable = 1'b1;
    end else begin : g_narrow
      // No upper half exists: high-half writes fall through to counting.
      assign hi_merged   = value_reg;
      assign hi_writable = 1'b0;
    end
  endgenerate

  always_comb begin
    value_next = value_reg;
    if (wr_lo) begin
      value_next[31:0] = wdata;
    end else if (wr_hi && hi_writable) begin
      value_next = hi_merged;
    end else if (inc && !inhibit) begin
      value_next = value_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core: CSR read-modify-write, trap entry,
// MRET, interrupt pending/priority and the cycle/time/instret/HPM counters.
module csr_file
  import csr_pkg::*;
#(
  parameter int          NUM_HPM     = 4,
  parameter int          CNT_WIDTH   = 64,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MARCHID_VAL = 32'h0000_2EF8,
  parameter logic [31:0] MIMPID_VAL  = 32'h0000_0002
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  csr_valid,
  input  logic [2:0]                            func3,
  input  logic [4:0]                            csr_immediate,
  input  logic [11:0]                           csr_address,
  input  logic [31:0]                           csr_data_in,
  output logic [31:0]                           csr_data_out,
  output logic                                  csr_illegal,
  input  logic                                  instr_retired,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
  input  logic                                  time_tick,
  input  logic                                  trap_valid,
  input  logic [31:0]                           trap_cause,
  input  logic [31:0]                           trap_pc,
  input  logic [31:0]                           trap_val,
  input  logic                                  mret_valid,
  input  logic                                  interruption_request_external,
  input  logic                                  interruption_request_timer,
  input  logic                                  interruption_request_software,
  input  logic [15:0]                           interruption_request_fast,
  output logic                                  irq_pending,
  output logic [31:0]                           irq_cause,
  output logic [31:0]                           trap_vector,
  output logic [31:0]                           mepc_out
);

  localparam int          NCNT         = CNT_IDX_HPM0 + NUM_HPM;
  localparam logic [31:0] CNTINH_WMASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

  logic        mstatus_mie_reg;
  logic        mstatus_mpie_reg;
  logic [31:0] mie_reg;
  logic [31:0] mtvec_reg;
  logic [31:0] mcountinhibit_reg;
  logic [31:0] mscratch_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic [31:0] mtval_reg;
  logic [31:0] mip_reg;

  logic [CNT_WIDTH-1:0] cnt_value [NCNT];
  logic [63:0]          cnt_wide  [NCNT];
  logic [NCNT-1:0]      cnt_inc;
  logic [NCNT-1:0]      cnt_wr_lo;
  logic [NCNT-1:0]      cnt_wr_hi;

  csr_op_e     op;
  logic [31:0] src;
  logic        write_intent;
  logic        implemented;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        csr_we;
  logic [31:0] mstatus_rd;
  logic [4:0]  cnt_idx;
  logic        cnt_hi;
  logic        cnt_space_m;
  logic        cnt_space_u;
  logic        cnt_idx_ok;
  logic [31:0] mip_pend;
  logic [4:0]  irq_code;
  logic [31:0] tvec_base;

  // ---------------------------------------------------------------- decode
  assign op           = csr_op_e'(func3[1:0]);
  assign src          = func3[2] ? {27'b0, csr_immediate} : csr_data_in;
  assign write_intent = (op == OP_RW) || (src != 32'b0);

  assign cnt_idx     = csr_address[4:0];
  assign cnt_hi      = csr_address[7];
  assign cnt_space_m = (csr_address[11:8] == 4'hB) && (csr_address[6:5] == 2'b00);
  assign cnt_space_u = (csr_address[11:8] == 4'hC) && (csr_address[6:5] == 2'b00);
  assign cnt_idx_ok  = int'(cnt_idx) < NCNT;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};

  always_comb begin
    rdata       = 32'b0;
    implemented = 1'b1;
    case (csr_address)
      CSR_MSTATUS:       rdata = mstatus_rd;
      CSR_MSTATUSH:      rdata = 32'b0;
      CSR_MISA:          rdata = MISA_VAL;
      CSR_MIE:           rdata = mie_reg;
      CSR_MTVEC:         rdata = mtvec_reg;
      CSR_MCOUNTINHIBIT: rdata = mcountinhibit_reg;
      CSR_MSCRATCH:      rdata = mscratch_reg;
      CSR_MEPC:          rdata = mepc_reg;
      CSR_MCAUSE:        rdata = mcause_reg;
      CSR_MTVAL:         rdata = mtval_reg;
      CSR_MIP:           rdata = mip_reg;
      CSR_MVENDORID:     rdata = 32'b0;
      CSR_MARCHID:       rdata = MARCHID_VAL;
      CSR_MIMPID:        rdata = MIMPID_VAL;
      CSR_MHARTID:       rdata = 32'b0;
      default: begin
        // Index 1 has no machine-mode alias (no mtime CSR here).
        implemented = cnt_idx_ok &&
                      (cnt_space_u || (cnt_space_m && int'(cnt_idx) != CNT_IDX_TIME));
        for (int i = 0; i < NCNT; i++) begin
          if (implemented && int'(cnt_idx) == i) begin
            rdata = cnt_hi ? cnt_wide[i][63:32] : cnt_wide[i][31:0];
          end
        end
      end
    endcase
  end

  assign csr_data_out = rdata;
  assign csr_illegal  = csr_valid &&
                        (!implemented || op == OP_NONE ||
                         (write_intent && csr_is_read_only(csr_address)));

  always_comb begin
    case (op)
      OP_RS:   wdata = rdata | src;
      OP_RC:   wdata = rdata & ~src;
      default: wdata = src;
    endcase
  end

  // Trap and MRET pre-empt any CSR write in the same cycle.
  assign csr_we = csr_valid && !csr_illegal && write_intent && !trap_valid && !mret_valid;

  // -------------------------------------------------------------- counters
  assign cnt_inc[CNT_IDX_CYCLE]   = 1'b1;
  assign cnt_inc[CNT_IDX_TIME]    = time_tick;
  assign cnt_inc[CNT_IDX_INSTRET] = instr_retired;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HPM; gi++) begin : g_hpm_inc
      assign cnt_inc[CNT_IDX_HPM0+gi] = hpm_event[gi];
    end

    for (gi = 0; gi < NCNT; gi++) begin : g_cnt
      logic inhibit;
      assign inhibit       = (gi == CNT_IDX_TIME) ? 1'b0 : mcountinhibit_reg[gi];
      assign cnt_wr_lo[gi] = csr_we && (gi != CNT_IDX_TIME) &&
                             (csr_address == (CSR_MCYCLE  | 12'(gi)));
      assign cnt_wr_hi[gi] = csr_we && (gi != CNT_IDX_TIME) &&
                             (csr_address == (CSR_MCYCLEH | 12'(gi)));
      assign cnt_wide[gi]  = 64'(cnt_value[gi]);

      csr_counter #(
        .CNT_WIDTH(CNT_WIDTH)
      ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .inc    (cnt_inc[gi]),
        .inhibit(inhibit),
        .wr_lo  (cnt_wr_lo[gi]),
        .wr_hi  (cnt_wr_hi[gi]),
        .wdata  (wdata),
        .value  (cnt_value[gi])
      );
    end
  endgenerate

  // ------------------------------------------------------------ interrupts
  assign mip_pend    = mip_reg & mie_reg;
  assign irq_pending = mstatus_mie_reg && (mip_pend != 32'b0);

  // Later assignments override earlier ones, so the last match has priority.
  always_comb begin
    irq_code = 5'd0;
    for (int i = 31; i >= 16; i--) begin
      if (mip_pend[i]) irq_code = 5'(i);
    end
    if (mip_pend[MIP_MTI]) irq_code = 5'(MIP_MTI);
    if (mip_pend[MIP_MSI]) irq_code = 5'(MIP_MSI);
    if (mip_pend[MIP_MEI]) irq_code = 5'(MIP_MEI);
  end

  assign irq_cause = irq_pending ? {1'b1, 26'b0, irq_code} : 32'b0;

  assign tvec_base   = {mtvec_reg[31:2], 2'b00};
  assign trap_vector = (mtvec_reg[0] && trap_cause[31])
                       ? tvec_base + {25'b0, trap_cause[4:0], 2'b00}
                       : tvec_base;
  assign mepc_out    = mepc_reg;

  // ----------------------------------------------------------------- state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstatus_mie_reg   <= 1'b0;
      mstatus_mpie_reg  <= 1'b0;
      mie_reg           <= 32'b0;
      mtvec_reg         <= RESET_MTVEC;
      mcountinhibit_reg <= 32'b0;
      mscratch_reg      <= 32'b0;
      mepc_reg          <= 32'b0;
      mcause_reg        <= 32'b0;
      mtval_reg         <= 32'b0;
      mip_reg           <= 32'b0;
    end else begin
      mip_reg <= {interruption_request_fast, 4'b0, interruption_request_external, 3'b0,
                  interruption_request_timer, 3'b0, interruption_request_software, 3'b0};
      if (trap_valid) begin
        mepc_reg         <= {trap_pc[31:2], 2'b00};
        mcause_reg       <= trap_cause;
        mtval_reg        <= trap_val;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (mret_valid) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end else if (csr_we) begin
        case (csr_address)
          CSR_MSTATUS: begin
            mstatus_mie_reg  <= wdata[MSTATUS_MIE];
            mstatus_mpie_reg <= wdata[MSTATUS_MPIE];
          end
          CSR_MIE:           mie_reg           <= wdata & MIE_WMASK;
          CSR_MTVEC:         mtvec_reg         <= wdata & ~32'h2;
          CSR_MCOUNTINHIBIT: mcountinhibit_reg <= wdata & CNTINH_WMASK;
          CSR_MSCRATCH:      mscratch_reg      <= wdata;
          CSR_MEPC:          mepc_reg          <= wdata & ~32'h3;
          CSR_MCAUSE:        mcause_reg        <= wdata;
          CSR_MTVAL:         mtval_reg         <= wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: expectations are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_csr_file;

  localparam int NUM_HPM = 4;
  localparam int SEL_PEND = 0, SEL_CAUSE = 1, SEL_TVEC = 2, SEL_MEPC = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        csr_valid = 1'b0;
  logic [2:0]  func3 = 3'b0;
  logic [4:0]  csr_immediate = 5'b0;
  logic [11:0] csr_address = 12'b0;
  logic [31:0] csr_data_in = 32'b0;
  logic [31:0] csr_data_out;
  logic        csr_illegal;
  logic        instr_retired = 1'b0;
  logic [NUM_HPM-1:0] hpm_event = '0;
  logic        time_tick = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_cause = 32'b0;
  logic [31:0] trap_pc = 32'b0;
  logic [31:0] trap_val = 32'b0;
  logic        mret_valid = 1'b0;
  logic        irq_ext = 1'b0, irq_tmr = 1'b0, irq_sw = 1'b0;
  logic [15:0] irq_fast = 16'b0;
  logic        irq_pending;
  logic [31:0] irq_cause, trap_vector, mepc_out;

  csr_file #(.NUM_HPM(NUM_HPM), .CNT_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .csr_valid(csr_valid), .func3(func3),
    .csr_immediate(csr_immediate), .csr_address(csr_address),
    .csr_data_in(csr_data_in), .csr_data_out(csr_data_out), .csr_illegal(csr_illegal),
    .instr_retired(instr_retired), .hpm_event(hpm_event), .time_tick(time_tick),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_val(trap_val), .mret_valid(mret_valid),
    .interruption_request_external(irq_ext), .interruption_request_timer(irq_tmr),
    .interruption_request_software(irq_sw), .interruption_request_fast(irq_fast),
    .irq_pending(irq_pending), .irq_cause(irq_cause), .trap_vector(trap_vector),
    .mepc_out(mepc_out)
  );

  always #10 clk = ~clk;

  // Model of mcycle while it is never inhibited or written: posedges out of reset.
  int unsigned cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= cyc + 1;
    else       cyc <= 0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    n_checks++;
    if (obs !== exp_val) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp_val);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One CSR instruction: drive, check the combinational response, take the edge.
  task automatic csr_op(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] zimm,
                        input logic chk_rd, input logic [31:0] exp_rd, input logic exp_ill);
    csr_valid = 1'b1; func3 = f3; csr_address = addr;
    csr_data_in = rs1; csr_immediate = zimm;
    if (chk_rd) sb_push({tag, ".rd"}, exp_rd);
    sb_push({tag, ".ill"}, {31'b0, exp_ill});
    #1;
    if (chk_rd) sb_pop(csr_data_out);
    sb_pop({31'b0, csr_illegal});
    step();
    csr_valid = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [11:0] addr, input logic [31:0] exp_val);
    csr_valid = 1'b0;
    csr_address = addr;
    sb_push(tag, exp_val);
    #1;
    sb_pop(csr_data_out);
  endtask

  task automatic expect_out(input string tag, input int sel, input logic [31:0] exp_val);
    sb_push(tag, exp_val);
    #1;
    case (sel)
      SEL_PEND:  sb_pop({31'b0, irq_pending});
      SEL_CAUSE: sb_pop(irq_cause);
      SEL_TVEC:  sb_pop(trap_vector);
      default:   sb_pop(mepc_out);
    endcase
  endtask

  typedef struct {
    logic        ext, tmr, sw;
    logic [15:0] fast;
    logic [31:0] cause;
  } irq_vec_t;

  irq_vec_t irq_tab [6];
  int unsigned frozen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    irq_tab[0] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 32'h8000_000B};
    irq_tab[1] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 32'h8000_0003};
    irq_tab[2] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 32'h8000_0007};
    irq_tab[3] = '{1'b0, 1'b0, 1'b0, 16'h0024, 32'h8000_0012};
    irq_tab[4] = '{1'b0, 1'b0, 1'b0, 16'h8000, 32'h8000_001F};
    irq_tab[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'h0000_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    expect_out("rst_irq_pending", SEL_PEND, 32'h0);
    expect_out("rst_irq_cause", SEL_CAUSE, 32'h0);
    expect_out("rst_mepc_out", SEL_MEPC, 32'h0);
    peek("rst_mstatus", 12'h300, 32'h0000_1800);
    peek("rst_mtvec", 12'h305, 32'h0);
    peek("rst_misa", 12'h301, 32'h4000_0100);
    peek("rst_marchid", 12'hF12, 32'h0000_2EF8);
    peek("rst_mcycle", 12'hB00, 32'h0);
    reset = 1'b1;
    step();

    // Read-modify-write on mscratch
    csr_op("rw_mscratch", 3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0, 1, 32'h0, 0);
    csr_op("rs_mscratch", 3'b010, 12'h340, 32'h0000_00F0, 5'd0, 1, 32'hDEAD_BEEF, 0);
    csr_op("rci_zimm0", 3'b111, 12'h340, 32'hFFFF_FFFF, 5'd0, 1, 32'hDEAD_BEFF, 0);
    peek("mscratch_after_rci0", 12'h340, 32'hDEAD_BEFF);
    csr_op("rci_zimm0f", 3'b111, 12'h340, 32'h0, 5'h0F, 1, 32'hDEAD_BEFF, 0);
    peek("mscratch_after_rci", 12'h340, 32'hDEAD_BEF0);

    // Legality
    csr_op("rw_cycle", 3'b001, 12'hC00, 32'h55, 5'd0, 1, cyc, 1);
    peek("mcycle_unwritten", 12'hB00, cyc);
    csr_op("rs_cycle_rs1_0", 3'b010, 12'hC00, 32'h0, 5'd0, 1, cyc, 0);
    csr_op("f3_000", 3'b000, 12'h340, 32'h1, 5'd0, 0, 32'h0, 1);
    csr_op("f3_100", 3'b100, 12'h340, 32'h1234, 5'd0, 0, 32'h0, 1);
    peek("mscratch_after_illegal", 12'h340, 32'hDEAD_BEF0);
    csr_op("unimpl_7c0", 3'b001, 12'h7C0, 32'h1, 5'd0, 0, 32'h0, 1);
    csr_op("unimpl_mtime", 3'b010, 12'hB01, 32'h0, 5'd0, 0, 32'h0, 1);
    csr_op("rw_mvendorid", 3'b001, 12'hF11, 32'h0, 5'd0, 1, 32'h0, 1);
    csr_op("rw_mip", 3'b001, 12'h344, 32'hFFFF_FFFF, 5'd0, 1, 32'h0, 0);
    peek("mip_ignored", 12'h344, 32'h0);

    // Inhibit, 32-bit carry, write-beats-increment
    csr_op("inh_all", 3'b001, 12'h320, 32'hFFFF_FFFF, 5'd0, 1, 32'h0, 0);
    frozen = cyc;
    peek("mcountinhibit_mask", 12'h320, 32'h0000_007D);
    step();
    step();
    peek("mcycle_frozen", 12'hB00, frozen);
    csr_op("wr_mcycle", 3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0, 1, frozen, 0);
    csr_op("wr_mcycleh", 3'b001, 12'hB80, 32'h0, 5'd0, 1, 32'h0, 0);
    csr_op("clr_inh", 3'b001, 12'h320, 32'h0, 5'd0, 1, 32'h0000_007D, 0);
    peek("mcycle_preroll", 12'hB00, 32'hFFFF_FFFF);
    step();
    peek("mcycleh_carry", 12'hB80, 32'h1);
    peek("mcycle_wrapped", 12'hB00, 32'h0);
    peek("cycleh_alias", 12'hC80, 32'h1);
    csr_op("wr_wins", 3'b001, 12'hB00, 32'h100, 5'd0, 1, 32'h0, 0);
    peek("mcycle_written", 12'hB00, 32'h100);
    step();
    peek("mcycle_resumes", 12'hB00, 32'h101);

    // instret / time / hpm counting
    instr_retired = 1'b1; time_tick = 1'b1; hpm_event = 4'b0001;
    repeat (3) step();
    instr_retired = 1'b0; time_tick = 1'b0; hpm_event = 4'b0000;
    peek("minstret", 12'hB02, 32'd3);
    peek("time", 12'hC01, 32'd3);
    peek("timeh", 12'hC81, 32'd0);
    peek("hpm3", 12'hB03, 32'd3);
    peek("hpm4", 12'hB04, 32'd0);
    csr_op("inh_hpm4", 3'b001, 12'h320, 32'h10, 5'd0, 1, 32'h0, 0);
    hpm_event = 4'b0011;
    repeat (2) step();
    hpm_event = 4'b0000;
    peek("hpm3_counted", 12'hB03, 32'd5);
    peek("hpm4_inhibited", 12'hC04, 32'd0);
    csr_op("clr_inh_hpm4", 3'b001, 12'h320, 32'h0, 5'd0, 1, 32'h10, 0);

    // Field masks
    csr_op("wr_mtvec", 3'b001, 12'h305, 32'h0000_1003, 5'd0, 1, 32'h0, 0);
    peek("mtvec_bit1", 12'h305, 32'h0000_1001);
    csr_op("wr_mepc", 3'b001, 12'h341, 32'h0000_0203, 5'd0, 1, 32'h0, 0);
    expect_out("mepc_low_bits", SEL_MEPC, 32'h0000_0200);
    csr_op("wr_mie_all", 3'b001, 12'h304, 32'hFFFF_FFFF, 5'd0, 1, 32'h0, 0);
    peek("mie_mask", 12'h304, 32'hFFFF_0888);
    csr_op("wr_mie_mei", 3'b001, 12'h304, 32'h0000_0800, 5'd0, 1, 32'hFFFF_0888, 0);
    csr_op("set_mstatus_mie", 3'b110, 12'h300, 32'h0, 5'd8, 1, 32'h0000_1800, 0);
    peek("mstatus_mie", 12'h300, 32'h0000_1808);

    // Interrupts
    irq_ext = 1'b1;
    expect_out("irq_not_yet", SEL_PEND, 32'h0);
    step();
    expect_out("irq_pending_ext", SEL_PEND, 32'h1);
    expect_out("irq_cause_ext", SEL_CAUSE, 32'h8000_000B);
    peek("mip_ext", 12'h344, 32'h0000_0800);
    csr_op("wr_mie_all2", 3'b001, 12'h304, 32'hFFFF_FFFF, 5'd0, 1, 32'h0000_0800, 0);
    for (int i = 0; i < 6; i++) begin
      irq_ext = irq_tab[i].ext; irq_tmr = irq_tab[i].tmr;
      irq_sw = irq_tab[i].sw; irq_fast = irq_tab[i].fast;
      step();
      expect_out($sformatf("prio%0d_cause", i), SEL_CAUSE, irq_tab[i].cause);
      expect_out($sformatf("prio%0d_pending", i), SEL_PEND, {31'b0, irq_tab[i].cause[31]});
    end
    irq_ext = 1'b1;
    step();
    csr_op("clr_mstatus_mie", 3'b111, 12'h300, 32'h0, 5'd8, 1, 32'h0000_1808, 0);
    expect_out("irq_masked_global", SEL_PEND, 32'h0);
    csr_op("set_mstatus_mie2", 3'b110, 12'h300, 32'h0, 5'd8, 1, 32'h0000_1800, 0);
    expect_out("irq_unmasked", SEL_PEND, 32'h1);

    // Trap entry; a concurrent CSR write must be dropped
    trap_valid = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h104; trap_val = 32'h77;
    expect_out("trap_vector_vectored", SEL_TVEC, 32'h0000_102C);
    csr_op("trap_drop_wr", 3'b001, 12'h340, 32'h1234, 5'd0, 1, 32'hDEAD_BEF0, 0);
    trap_valid = 1'b0;
    expect_out("trap_mepc", SEL_MEPC, 32'h104);
    peek("trap_mstatus", 12'h300, 32'h0000_1880);
    peek("trap_mcause", 12'h342, 32'h8000_000B);
    peek("trap_mtval", 12'h343, 32'h77);
    peek("trap_mscratch_kept", 12'h340, 32'hDEAD_BEF0);
    expect_out("trap_irq_off", SEL_PEND, 32'h0);
    trap_cause = 32'h5;
    expect_out("trap_vector_exc", SEL_TVEC, 32'h0000_1000);
    trap_cause = 32'h8000_0010;
    expect_out("trap_vector_fast", SEL_TVEC, 32'h0000_1040);

    // MRET, then trap and MRET together
    mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    peek("mret_mstatus", 12'h300, 32'h0000_1888);
    expect_out("mret_mepc_out", SEL_MEPC, 32'h104);
    expect_out("mret_irq_back", SEL_PEND, 32'h1);
    trap_valid = 1'b1; mret_valid = 1'b1;
    trap_cause = 32'h2; trap_pc = 32'h300; trap_val = 32'h0;
    step();
    trap_valid = 1'b0; mret_valid = 1'b0;
    peek("trap_mret_mstatus", 12'h300, 32'h0000_1880);
    expect_out("trap_mret_mepc", SEL_MEPC, 32'h300);
    peek("trap_mret_mcause", 12'h342, 32'h2);

    // Asynchronous reset in the middle of activity
    instr_retired = 1'b1;
    repeat (3) step();
    peek("minstret_pre_reset", 12'hB02, 32'd6);
    csr_valid = 1'b1; func3 = 3'b001; csr_address = 12'h340; csr_data_in = 32'h5555;
    reset = 1'b0;
    #1;
    csr_valid = 1'b0;
    peek("arst_mcycle", 12'hB00, 32'h0);
    peek("arst_mcycleh", 12'hB80, 32'h0);
    peek("arst_minstret", 12'hB02, 32'h0);
    peek("arst_time", 12'hC01, 32'h0);
    peek("arst_hpm3", 12'hB03, 32'h0);
    peek("arst_mscratch", 12'h340, 32'h0);
    peek("arst_mstatus", 12'h300, 32'h0000_1800);
    expect_out("arst_irq_pending", SEL_PEND, 32'h0);
    expect_out("arst_irq_cause", SEL_CAUSE, 32'h0);
    expect_out("arst_mepc_out", SEL_MEPC, 32'h0);
    instr_retired = 1'b0;
    step();
    peek("arst_write_discarded", 12'h340, 32'h0);
    reset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
